// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK levels,
// the per-byte bit count and the majority vote used by the line glitch filter.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [3:0] I2C_BITS = 4'd8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchroniser, optional 3-sample majority filter
// (enabled by I2C_TGT_FILTER_EN), SCL edge and START/STOP detection.
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_line_s;
  logic       sda_line_s;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Bring the asynchronous bus lines into the clk domain; idle bus is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TGT_FILTER_EN
  logic [2:0] scl_hist_q;
  logic [2:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // A level must be seen in two of the last three samples to pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_hist_q);
      sda_filt_q <= maj3(sda_hist_q);
    end
  end

  assign scl_line_s = scl_filt_q;
  assign sda_line_s = sda_filt_q;
`else
  assign scl_line_s = scl_sync_q[1];
  assign sda_line_s = sda_sync_q[1];
`endif

  // Previous conditioned levels for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_line_s;
      sda_prev_q <= sda_line_s;
    end
  end

  assign sda_o      = sda_line_s;
  assign scl_rise_o = scl_line_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_line_s & scl_prev_q;
  // SDA may only move while SCL is low; an SDA edge under a stable-high SCL is a bus condition.
  assign start_o    = scl_line_s & scl_prev_q & sda_prev_q & ~sda_line_s;
  assign stop_o     = scl_line_s & scl_prev_q & ~sda_prev_q & sda_line_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target at DEV_ADDR: write transfers set a register pointer and emit data
// strobes, read transfers stream reg_rdata. Glitch filter via I2C_TGT_FILTER_EN.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h60,
  parameter int         PTR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  inout  wire              sda,
  output logic             reg_wr,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  i2c_state_e       state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             drive_q, drive_d;
  logic             rw_q, rw_d;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;

  logic             sda_s;
  logic             scl_rise_s;
  logic             scl_fall_s;
  logic             start_s;
  logic             stop_s;
  logic [7:0]       rx_byte_s;

  i2c_line_cond u_line_cond (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  assign rx_byte_s = {shift_q[6:0], sda_s};

  // Protocol FSM: bus conditions first, then SCL rise (sample) / fall (drive).
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    drive_d  = drive_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    busy_d   = busy_q;
    if (start_s) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      drive_d  = 1'b0;
    end else if (stop_s) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      drive_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_d  = rx_byte_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == I2C_BITS - 4'd1) begin
              case (state_q)
                ST_ADDR: begin
                  rw_d    = sda_s;
                  state_d = (rx_byte_s[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_PTR: begin
                  addr_d  = PTR_W'(rx_byte_s);
                  state_d = ST_PTR_ACK;
                end
                ST_WDATA: begin
                  wdata_d = rx_byte_s;
                  wr_d    = 1'b1;
                  state_d = ST_WDATA_ACK;
                end
                default: state_d = ST_IDLE;
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        // Own ACK: the first fall starts driving 0, the second fall ends the ACK slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s && !drive_q) begin
            drive_d = 1'b1;
          end else if (scl_fall_s) begin
            drive_d  = 1'b0;
            bitcnt_d = 4'd0;
            case (state_q)
              ST_ADDR_ACK: begin
                if (rw_q) begin
                  state_d = ST_RDATA;
                  shift_d = reg_rdata;
                  drive_d = ~reg_rdata[7];
                end else begin
                  state_d = ST_PTR;
                end
              end
              ST_PTR_ACK:   state_d = ST_WDATA;
              ST_WDATA_ACK: begin
                state_d = ST_WDATA;
                addr_d  = addr_q + PTR_W'(1);
              end
              default:      state_d = ST_IDLE;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        // The rise shifts the next bit into shift_q[7]; the following fall puts it on SDA.
        ST_RDATA: begin
          if (scl_rise_s) begin
            shift_d  = rx_byte_s;
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bitcnt_q == I2C_BITS) begin
              drive_d = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              drive_d = ~shift_q[7];
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              addr_d = addr_q + PTR_W'(1);
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall_s) begin
            state_d  = ST_RDATA;
            bitcnt_d = 4'd0;
            shift_d  = reg_rdata;
            drive_d  = ~reg_rdata[7];
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          drive_d = 1'b0;
          state_d = state_q;
        end
      endcase
    end
    if (state_d == ST_IDLE || state_d == ST_IGNORE) begin
      busy_d = 1'b0;
    end else if (state_d == ST_ADDR_ACK) begin
      busy_d = 1'b1;
    end else begin
      busy_d = busy_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 4'd0;
      shift_q  <= 8'd0;
      drive_q  <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'd0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      drive_q  <= drive_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign sda       = drive_q ? 1'b0 : 1'bz;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bus-functional I2C master, scoreboarded reg_wr
// strobes and master-observed ACK/read bytes.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_w;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  pullup (sda_w);
  assign sda_w     = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = ~reg_addr;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h60), .PTR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda_w),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  int          total = 0;
  int          bad   = 0;
  int          q     = 625;
  logic        watch_rel = 1'b0;
  int          rel_viol  = 0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_bus_q[$];
  string       tag_q[$];
  logic [7:0]  obs_q[$];
  event        obs_ev;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Register-write monitor
  always @(negedge clk) begin
    if (rst_n && reg_wr) begin
      if (exp_wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL reg_wr_unexpected: got %h/%h expected none", reg_addr, reg_wdata);
      end else begin
        chk("reg_wr addr/data", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
      end
    end
  end

  // Bus-observation monitor
  initial begin
    forever begin
      @(obs_ev);
      while (obs_q.size() > 0) begin
        if (exp_bus_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected: got %h expected none", obs_q.pop_front());
        end else begin
          chk(tag_q.pop_front(), {8'd0, obs_q.pop_front()}, {8'd0, exp_bus_q.pop_front()});
        end
      end
    end
  end

  // Watch an ignored transfer: target must never pull SDA low nor report busy
  always @(negedge clk) begin
    if (watch_rel) begin
      if (!m_low && sda_w == 1'b0) rel_viol++;
      if (busy) rel_viol++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    m_low = 1'b0; #(q); scl = 1'b1; #(q); m_low = 1'b1; #(q); scl = 1'b0; #(q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #(q); scl = 1'b1; #(q); m_low = 1'b0; #(q);
  endtask

  task automatic bit_w(input logic b);
    m_low = ~b; #(q); scl = 1'b1; #(2*q); scl = 1'b0; #(q);
  endtask

  task automatic bit_glitch1();
    m_low = 1'b0; #(q); scl = 1'b1; #(q);
    m_low = 1'b1; #10; m_low = 1'b0;
    #(q-10); scl = 1'b0; #(q);
  endtask

  task automatic bit_r(output logic b);
    m_low = 1'b0; #(q); scl = 1'b1; #(q); b = sda_w; #(q); scl = 1'b0; #(q);
  endtask

  task automatic wbyte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic a;
    exp_bus_q.push_back({7'd0, exp_ack});
    tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    bit_r(a);
    obs_q.push_back({7'd0, a});
    ->obs_ev;
  endtask

  task automatic rbyte(input logic [7:0] exp, input logic m_ack, input string tag);
    logic [7:0] v;
    logic       b;
    exp_bus_q.push_back(exp);
    tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      v[i] = b;
    end
    obs_q.push_back(v);
    ->obs_ev;
    bit_w(m_ack);
  endtask

  initial begin
    #50;
    chk("reset reg_wr", {15'd0, reg_wr}, 16'd0);
    chk("reset reg_addr", {8'd0, reg_addr}, 16'd0);
    chk("reset reg_wdata", {8'd0, reg_wdata}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset sda", {15'd0, sda_w}, 16'd1);
    #50 rst_n = 1'b1;
    #200;

    // Two-byte register write at 100 kHz
    q = 2500;
    exp_wr_q.push_back(16'h10AA);
    exp_wr_q.push_back(16'h1155);
    i2c_start();
    wbyte(8'hC0, 1'b0, "t1 addr ack");
    wbyte(8'h10, 1'b0, "t1 ptr ack");
    wbyte(8'hAA, 1'b0, "t1 d0 ack");
    wbyte(8'h55, 1'b0, "t1 d1 ack");
    chk("t1 busy before stop", {15'd0, busy}, 16'd1);
    i2c_stop();
    #100;
    chk("t1 busy after stop", {15'd0, busy}, 16'd0);

    // Pointer write, repeated START, two-byte read at 400 kHz
    q = 625;
    i2c_start();
    wbyte(8'hC0, 1'b0, "t2 addr ack");
    wbyte(8'h03, 1'b0, "t2 ptr ack");
    i2c_start();
    wbyte(8'hC1, 1'b0, "t2 raddr ack");
    rbyte(8'hFC, 1'b0, "t2 rd0");
    rbyte(8'hFB, 1'b1, "t2 rd1");
    chk("t2 sda released after nack", {15'd0, sda_w}, 16'd1);
    chk("t2 busy after nack", {15'd0, busy}, 16'd0);
    i2c_stop();

    // Foreign address is NACKed and never touched
    watch_rel = 1'b1;
    i2c_start();
    wbyte(8'hA0, 1'b1, "t3 foreign nack");
    i2c_stop();
    watch_rel = 1'b0;
    chk("t3 sda/busy untouched", 16'(rel_viol), 16'd0);

    // Pointer wrap
    exp_wr_q.push_back(16'hFF11);
    exp_wr_q.push_back(16'h0022);
    i2c_start();
    wbyte(8'hC0, 1'b0, "t4 addr ack");
    wbyte(8'hFF, 1'b0, "t4 ptr ack");
    wbyte(8'h11, 1'b0, "t4 d0 ack");
    wbyte(8'h22, 1'b0, "t4 d1 ack");
    i2c_stop();

    // STOP inside a data byte, then a normal transfer
    i2c_start();
    wbyte(8'hC0, 1'b0, "t5 addr ack");
    wbyte(8'h40, 1'b0, "t5 ptr ack");
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    i2c_stop();
    exp_wr_q.push_back(16'h4177);
    i2c_start();
    wbyte(8'hC0, 1'b0, "t5b addr ack");
    wbyte(8'h41, 1'b0, "t5b ptr ack");
    wbyte(8'h77, 1'b0, "t5b d0 ack");
    i2c_stop();

`ifdef I2C_TGT_FILTER_EN
    // 1-clk SDA glitch while SCL is high must not be seen as START/STOP
    exp_wr_q.push_back(16'h5081);
    i2c_start();
    wbyte(8'hC0, 1'b0, "t6 addr ack");
    wbyte(8'h50, 1'b0, "t6 ptr ack");
    exp_bus_q.push_back(8'd0);
    tag_q.push_back("t6 glitch data ack");
    begin
      logic a;
      bit_w(1'b1);
      for (int i = 0; i < 6; i++) bit_w(1'b0);
      bit_glitch1();
      bit_r(a);
      obs_q.push_back({7'd0, a});
      ->obs_ev;
    end
    i2c_stop();
`endif

    // Reset pulse while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_w(i == 7 || i == 6);
    m_low = 1'b0;
    #(q);
    chk("t7 ack driven", {15'd0, sda_w}, 16'd0);
    chk("t7 busy before reset", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t7 sda released by reset", {15'd0, sda_w}, 16'd1);
    chk("t7 busy in reset", {15'd0, busy}, 16'd0);
    chk("t7 reg_addr in reset", {8'd0, reg_addr}, 16'd0);
    #9 rst_n = 1'b1;
    #(q-10); scl = 1'b1; #(2*q); scl = 1'b0; #(q);
    chk("t7 sda idle after reset", {15'd0, sda_w}, 16'd1);
    i2c_stop();

    #1000;
    chk("pending reg_wr", 16'(exp_wr_q.size()), 16'd0);
    chk("pending bus checks", 16'(exp_bus_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
